// File: rtl/dmem_responder.sv
// dmem_responder: handshaked load/store data-memory target with a fixed
// number of wait states between request acceptance and response.
// Optional feature macro: ADDR_ERR_EN (flags misaligned / out-of-range
// addresses on resp_err and suppresses the access).
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    COMMIT,
    RESP
  } state_t;

  state_t state, state_next;

  logic [3:0]            cnt;
  logic                  lat_write;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           rdata_q;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  in_range;
  logic                  addr_ok;
  logic                  accept;

  // NOTE: the RAM array has no reset; clearing every word would need a
  // reset port on every cell and contents must survive a reset anyway.
  logic [31:0] mem [DEPTH];

  assign accept   = (state == IDLE) && req_valid;
  assign word_idx = lat_addr[DEPTH_LOG2+1:2];
  assign in_range = (lat_addr[31:DEPTH_LOG2+2] == '0);

`ifdef ADDR_ERR_EN
  logic misaligned;
  logic err_q;

  assign misaligned = |lat_addr[1:0];
  assign addr_ok    = in_range && !misaligned;
  assign resp_err   = err_q;

  // Error flag captured at commit and held through the response phase.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      err_q <= 1'b0;
    end else if (state == COMMIT) begin
      err_q <= !addr_ok;
    end
  end
`else
  // Byte-offset bits only matter when address errors are reported.
  logic unused_offset;

  assign unused_offset = ^lat_addr[1:0];
  assign addr_ok       = in_range;
  assign resp_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  // NOTE: every output gets a default before the case so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (WAIT_CYCLES > 0) ? BUSY : COMMIT;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture and wait-state counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      cnt       <= WAIT_INIT;
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response data: load result or zero, captured in the commit cycle.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rdata_q <= 32'd0;
    end else if (state == COMMIT) begin
      if (!lat_write && addr_ok) begin
        rdata_q <= mem[word_idx];
      end else begin
        rdata_q <= 32'd0;
      end
    end
  end

  assign resp_rdata = rdata_q;

  // RAM write port; only a store reaching commit with a good address lands.
  always_ff @(posedge CLK) begin
    if ((state == COMMIT) && lat_write && addr_ok) begin
      mem[word_idx] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed transactions on a WAIT_CYCLES=2
// instance checked every cycle against a transaction-level model, plus a
// WAIT_CYCLES=0 instance checked with literal expectations.
module tb_dmem_responder;

  localparam int DL = 8;
  localparam int W  = 2;
`ifdef ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic [1:0]  rdy, vld, er;
  logic [31:0] rd [2];
  bit          cmp_en;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) u_dut (
    .CLK(clk), .Reset_L(rst_n),
    .req_valid(req_valid[0]), .req_ready(rdy[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[0]), .resp_ready(resp_ready),
    .resp_rdata(rd[0]), .resp_err(er[0])
  );

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) u_dut_w0 (
    .CLK(clk), .Reset_L(rst_n),
    .req_valid(req_valid[1]), .req_ready(rdy[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[1]), .resp_ready(resp_ready),
    .resp_rdata(rd[1]), .resp_err(er[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model of the W=2 instance ----------
  // m_age counts edges since acceptance: response is due once m_age > W,
  // the memory effect lands on the edge that makes m_age == W+1.
  logic [31:0] m_mem [int];
  bit          m_busy;
  int          m_age;
  bit          m_w;
  logic [31:0] m_a, m_d, m_rdata;
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
    end else if (!m_busy) begin
      if (req_valid[0]) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_w    = req_write;
        m_a    = req_addr;
        m_d    = req_wdata;
      end
    end else if (m_age >= W + 1) begin
      if (resp_ready) m_busy = 1'b0;
    end else begin
      m_age++;
      if (m_age == W + 1) begin
        bit in_range, ok;
        int idx;
        in_range = (m_a >> (DL + 2)) == 0;
        m_err    = ERR_EN && (((m_a % 4) != 0) || !in_range);
        ok       = in_range && !m_err;
        idx      = int'((m_a / 4) % (1 << DL));
        if (m_w) begin
          if (ok) m_mem[idx] = m_d;
          m_rdata = 32'd0;
        end else if (!ok) begin
          m_rdata = 32'd0;
        end else begin
          m_rdata = m_mem.exists(idx) ? m_mem[idx] : 32'hxxxx_xxxx;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit exp_valid;
      exp_valid = m_busy && (m_age >= W + 1);
      check("model_req_ready", 32'(rdy[0]), 32'(!m_busy));
      check("model_resp_valid", 32'(vld[0]), 32'(exp_valid));
      if (exp_valid) begin
        check("model_resp_rdata", rd[0], m_rdata);
        check("model_resp_err", 32'(er[0]), 32'(m_err));
      end
    end
  end

  // ---------------- directed stimulus helpers -----------------------------
  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input int sel, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input string name);
    int n;
    req_write      = w;
    req_addr       = a;
    req_wdata      = d;
    req_valid[sel] = 1'b1;
    n = 0;
    while (rdy[sel] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
  endtask

  task automatic collect(input int sel, input int hold, input int exp_lat,
                         input logic [31:0] exp_rdata, input bit exp_err,
                         input string name);
    int lat;
    lat = 1;
    while (vld[sel] !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_rdata"}, rd[sel], exp_rdata);
    check({name, "_err"}, 32'(er[sel]), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 32'(vld[sel]), 32'd1);
      check({name, "_hold_rdata"}, rd[sel], exp_rdata);
      check({name, "_hold_ready"}, 32'(rdy[sel]), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_idle_ready"}, 32'(rdy[sel]), 32'd1);
    check({name, "_idle_valid"}, 32'(vld[sel]), 32'd0);
  endtask

  task automatic txn(input int sel, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input int hold, input int exp_lat,
                     input logic [31:0] exp_rdata, input bit exp_err,
                     input string name);
    if (hold > 0) resp_ready = 1'b0;
    issue(sel, w, a, d, name);
    collect(sel, hold, exp_lat, exp_rdata, exp_err, name);
  endtask

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- directed sequence ------------------------------------
  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    cmp_en     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_req_ready", 32'(rdy[s]), 32'd1);
      check("reset_resp_valid", 32'(vld[s]), 32'd0);
      check("reset_resp_rdata", rd[s], 32'd0);
      check("reset_resp_err", 32'(er[s]), 32'd0);
    end
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Store/load round trip, four edges from accept to response.
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 4, 32'h0, 1'b0, "store_10");
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 4, 32'hDEAD_BEEF, 1'b0, "load_10");

    // Response backpressure for five cycles.
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 5, 4, 32'hDEAD_BEEF, 1'b0, "bp_load_10");

    // Reset in BUSY drops the pending store.
    txn(0, 1'b1, 32'h0000_0008, 32'h0, 0, 4, 32'h0, 1'b0, "store_8_zero");
    issue(0, 1'b1, 32'h0000_0008, 32'hAAAA_5555, "aborted_store_8");
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_ready", 32'(rdy[0]), 32'd1);
    check("abort_resp_valid", 32'(vld[0]), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h0000_0008, 32'h0, 0, 4, 32'h0, 1'b0, "load_8_after_abort");

    // Out-of-range: 0x400 would alias word 0 if the upper bits were ignored.
    txn(0, 1'b1, 32'h0000_0000, 32'h1122_3344, 0, 4, 32'h0, 1'b0, "store_0");
    txn(0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 0, 4, 32'h0, ERR_EN, "store_oor");
    txn(0, 1'b0, 32'h0000_0000, 32'h0, 0, 4, 32'h1122_3344, 1'b0, "load_0");
    txn(0, 1'b0, 32'h0000_0400, 32'h0, 0, 4, 32'h0, ERR_EN, "load_oor");

    // Misaligned accesses.
`ifdef ADDR_ERR_EN
    txn(0, 1'b0, 32'h0000_0012, 32'h0, 0, 4, 32'h0, 1'b1, "load_misaligned");
    txn(0, 1'b1, 32'h0000_0013, 32'h5555_5555, 0, 4, 32'h0, 1'b1, "store_misaligned");
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 4, 32'hDEAD_BEEF, 1'b0, "load_aligned_10");
`else
    txn(0, 1'b0, 32'h0000_0012, 32'h0, 0, 4, 32'hDEAD_BEEF, 1'b0, "load_truncated");
    txn(0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 0, 4, 32'h0, 1'b0, "store_truncated");
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 4, 32'hCAFE_F00D, 1'b0, "load_aligned_10");
`endif

    // Zero-wait-state instance: response two edges after accept, back to back.
    txn(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 0, 2, 32'h0, 1'b0, "w0_store_4");
    txn(1, 1'b0, 32'h0000_0004, 32'h0, 0, 2, 32'h1234_5678, 1'b0, "w0_load_4");

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
